// File: rtl/systolic_matmul_stream_if.sv
// Beat stream and result bus for systolic_matmul_stream.
// master = feeder/checker side, slave = the multiplier.
interface systolic_matmul_stream_if #(
    parameter int SIZE       = 4,
    parameter int I_BITS     = 8,
    parameter int O_BITS     = 16,
    parameter int MAX_DEPTH  = 16,
    parameter int DEPTH_BITS = $clog2(MAX_DEPTH + 1)
);
    logic                          i_valid;
    logic                          o_ready;
    logic [DEPTH_BITS-1:0]         i_depth;
    logic [SIZE*I_BITS-1:0]        i_a_full;
    logic [SIZE*I_BITS-1:0]        i_b_full;
    logic [SIZE*SIZE*O_BITS-1:0]   o_c_full;
    logic                          o_c_valid;
    logic                          o_busy;
    logic                          o_sat;

    modport master (
        output i_valid, i_depth, i_a_full, i_b_full,
        input  o_ready, o_c_full, o_c_valid, o_busy, o_sat
    );

    modport slave (
        input  i_valid, i_depth, i_a_full, i_b_full,
        output o_ready, o_c_full, o_c_valid, o_busy, o_sat
    );
endinterface

// File: rtl/systolic_matmul_stream.sv
// Output-stationary streaming systolic C = A*B with runtime depth K.
// Define SYSTOLIC_SAT_EN for saturating accumulators and sticky o_sat.
module systolic_matmul_stream #(
    parameter int SIZE       = 4,
    parameter int I_BITS     = 8,
    parameter int O_BITS     = 16,
    parameter int MAX_DEPTH  = 16,
    parameter int DEPTH_BITS = $clog2(MAX_DEPTH + 1)
) (
    input logic                    i_clock,
    input logic                    i_reset,
    systolic_matmul_stream_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

    localparam int FB = $clog2(2 * SIZE) + 1;
    localparam logic [FB-1:0] FLUSH_LEN = FB'(2 * SIZE - 1);

    state_t                      r_state;
    state_t                      w_next;
    logic [DEPTH_BITS-1:0]       r_depth;
    logic [DEPTH_BITS-1:0]       r_count;
    logic [DEPTH_BITS-1:0]       w_count_inc;
    logic [FB-1:0]               r_flush;
    logic                        r_ready;
    logic                        r_busy;
    logic                        r_c_valid;
    logic [SIZE*SIZE*O_BITS-1:0] r_c_full;
    logic [SIZE*SIZE*O_BITS-1:0] w_c_flat;

    logic w_depth_ok;
    logic w_fire;
    logic w_first;
    logic w_push;

    assign w_depth_ok  = (bus.i_depth != '0) &&
                         (bus.i_depth <= DEPTH_BITS'(MAX_DEPTH));
    assign w_fire      = bus.i_valid & r_ready;
    assign w_first     = w_fire & (r_state == IDLE) & w_depth_ok;
    assign w_push      = w_first | (w_fire & (r_state == LOAD));
    assign w_count_inc = r_count + DEPTH_BITS'(1);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:  if (w_first)
                       w_next = (bus.i_depth == DEPTH_BITS'(1)) ? FLUSH : LOAD;
            LOAD:  if (w_push && (w_count_inc == r_depth))
                       w_next = FLUSH;
            FLUSH: if (r_flush == '0)
                       w_next = DONE;
            DONE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_depth   <= '0;
            r_count   <= '0;
            r_flush   <= '0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_c_valid <= 1'b0;
            r_c_full  <= '0;
        end else begin
            r_state <= w_next;
            if (w_first) begin
                r_depth <= bus.i_depth;
                r_count <= DEPTH_BITS'(1);
            end else if (w_push) begin
                r_count <= w_count_inc;
            end
            // Drain time lets the last beat cross the full skewed array.
            if (w_next == FLUSH && r_state != FLUSH)
                r_flush <= FLUSH_LEN;
            else if (r_state == FLUSH)
                r_flush <= r_flush - FB'(1);
            r_ready   <= (w_next == IDLE) || (w_next == LOAD);
            r_busy    <= (w_next == LOAD) || (w_next == FLUSH);
            r_c_valid <= (r_state == DONE);
            if (r_state == DONE)
                r_c_full <= w_c_flat;
        end
    end

    logic signed [I_BITS-1:0] w_a_push [SIZE];
    logic signed [I_BITS-1:0] w_b_push [SIZE];
    logic signed [I_BITS-1:0] w_a_edge [SIZE];
    logic signed [I_BITS-1:0] w_b_edge [SIZE];
    logic signed [I_BITS-1:0] w_a_fwd  [SIZE][SIZE-1];
    logic signed [I_BITS-1:0] w_b_fwd  [SIZE-1][SIZE];

`ifdef SYSTOLIC_SAT_EN
    localparam logic signed [O_BITS-1:0] ACC_MAX = {1'b0, {(O_BITS-1){1'b1}}};
    localparam logic signed [O_BITS-1:0] ACC_MIN = {1'b1, {(O_BITS-1){1'b0}}};
    logic [SIZE*SIZE-1:0] w_clip;
    logic                 r_sat;

    always_ff @(posedge i_clock) begin
        if (i_reset)
            r_sat <= 1'b0;
        else if (w_first)
            r_sat <= |w_clip;
        else
            r_sat <= r_sat | (|w_clip);
    end
    assign bus.o_sat = r_sat;
`else
    assign bus.o_sat = 1'b0;
`endif

    for (genvar i = 0; i < SIZE; i++) begin : g_skew
        assign w_a_push[i] = w_push ?
            $signed(bus.i_a_full[i*I_BITS +: I_BITS]) : '0;
        assign w_b_push[i] = w_push ?
            $signed(bus.i_b_full[i*I_BITS +: I_BITS]) : '0;
        if (i == 0) begin : g_nodly
            assign w_a_edge[i] = w_a_push[i];
            assign w_b_edge[i] = w_b_push[i];
        end else begin : g_dly
            logic signed [I_BITS-1:0] r_ska [i];
            logic signed [I_BITS-1:0] r_skb [i];
            always_ff @(posedge i_clock) begin
                if (i_reset) begin
                    for (int k = 0; k < i; k++) begin
                        r_ska[k] <= '0;
                        r_skb[k] <= '0;
                    end
                end else begin
                    r_ska[0] <= w_a_push[i];
                    r_skb[0] <= w_b_push[i];
                    for (int k = 1; k < i; k++) begin
                        r_ska[k] <= r_ska[k-1];
                        r_skb[k] <= r_skb[k-1];
                    end
                end
            end
            assign w_a_edge[i] = r_ska[i-1];
            assign w_b_edge[i] = r_skb[i-1];
        end
    end

    for (genvar i = 0; i < SIZE; i++) begin : g_row
        for (genvar j = 0; j < SIZE; j++) begin : g_col
            logic signed [I_BITS-1:0]   w_a;
            logic signed [I_BITS-1:0]   w_b;
            logic signed [2*I_BITS-1:0] w_prod;
            logic signed [O_BITS-1:0]   w_base;
            logic signed [O_BITS-1:0]   w_nxt;
            logic signed [O_BITS-1:0]   r_acc;

            if (j == 0) begin : g_al
                assign w_a = w_a_edge[i];
            end else begin : g_ar
                assign w_a = w_a_fwd[i][j-1];
            end
            if (i == 0) begin : g_bt
                assign w_b = w_b_edge[j];
            end else begin : g_bb
                assign w_b = w_b_fwd[i-1][j];
            end

            assign w_prod = w_a * w_b;
            // First beat restarts every PE; only PE(0,0) sees real data then.
            assign w_base = w_first ? '0 : r_acc;

`ifdef SYSTOLIC_SAT_EN
            logic signed [O_BITS:0] w_sum;
            assign w_sum = $signed({w_base[O_BITS-1], w_base}) +
                           (O_BITS+1)'(w_prod);
            assign w_clip[i*SIZE+j] = w_sum[O_BITS] ^ w_sum[O_BITS-1];
            assign w_nxt = w_clip[i*SIZE+j] ?
                           (w_sum[O_BITS] ? ACC_MIN : ACC_MAX) :
                           w_sum[O_BITS-1:0];
`else
            assign w_nxt = w_base + O_BITS'(w_prod);
`endif

            always_ff @(posedge i_clock) begin
                if (i_reset)
                    r_acc <= '0;
                else
                    r_acc <= w_nxt;
            end
            assign w_c_flat[(i*SIZE+j)*O_BITS +: O_BITS] = r_acc;

            if (j < SIZE - 1) begin : g_af
                logic signed [I_BITS-1:0] r_a;
                always_ff @(posedge i_clock) begin
                    if (i_reset)
                        r_a <= '0;
                    else
                        r_a <= w_a;
                end
                assign w_a_fwd[i][j] = r_a;
            end
            if (i < SIZE - 1) begin : g_bf
                logic signed [I_BITS-1:0] r_b;
                always_ff @(posedge i_clock) begin
                    if (i_reset)
                        r_b <= '0;
                    else
                        r_b <= w_b;
                end
                assign w_b_fwd[i][j] = r_b;
            end
        end
    end

    assign bus.o_ready   = r_ready;
    assign bus.o_busy    = r_busy;
    assign bus.o_c_valid = r_c_valid;
    assign bus.o_c_full  = r_c_full;
endmodule
